// File: rtl/mpu_i2c_sequencer.sv
// MPU-6050 gyro link sequencer: power-up configuration, then periodic burst reads over a byte-level I2C master.
// Define MPU_TEMP_EN to also read TEMP_OUT and present it on temp_out.
module mpu_i2c_sequencer #(
  parameter logic [6:0] DEV_ADDR   = 7'h68,
  parameter int         SAMPLE_DIV = 50000,
  parameter int         INIT_DELAY = 5000000,
  parameter logic [1:0] GYRO_FS    = 2'b00
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en_in,
  output logic        cmd_valid_out,
  input  logic        cmd_ready_in,
  output logic [2:0]  cmd_op_out,
  output logic [7:0]  cmd_data_out,
  input  logic        rsp_valid_in,
  input  logic [7:0]  rsp_data_in,
  input  logic        rsp_nack_in,
  output logic [15:0] gx_out,
  output logic [15:0] gy_out,
  output logic [15:0] gz_out,
  output logic        sample_valid_out,
  output logic        busy_out,
  output logic        error_out,
  output logic        overrun_out
`ifdef MPU_TEMP_EN
  ,
  output logic [15:0] temp_out
`endif
);

  localparam logic [2:0] OP_START = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_RACK  = 3'd2;
  localparam logic [2:0] OP_RNACK = 3'd3;
  localparam logic [2:0] OP_STOP  = 3'd4;

`ifdef MPU_TEMP_EN
  localparam int         NBYTES = 8;
  localparam logic [7:0] RD_PTR = 8'h41;
`else
  localparam int         NBYTES = 6;
  localparam logic [7:0] RD_PTR = 8'h43;
`endif
  localparam int          BW           = NBYTES * 8;
  localparam logic [3:0]  RD_NACK_STEP = 4'(4 + NBYTES);
  localparam logic [3:0]  RD_LAST_STEP = 4'(5 + NBYTES);
  localparam logic [7:0]  ADDR_W       = {DEV_ADDR, 1'b0};
  localparam logic [7:0]  ADDR_R       = {DEV_ADDR, 1'b1};
  localparam logic [31:0] DELAY_LAST   = (INIT_DELAY > 0) ? 32'(INIT_DELAY - 1) : 32'd0;
  localparam logic [31:0] DIV_LAST     = 32'(SAMPLE_DIV - 1);

  // state     | meaning
  // BOOT_WAIT | settle delay after reset or error
  // CFG_PWR   | write PWR_MGMT_1 = 0 (wake)
  // CFG_GYRO  | write GYRO_CONFIG full-scale
  // IDLE      | configured, waiting for a sample tick
  // READ      | burst read of the sample registers
  // ABORT     | STOP after a NACK, then reconfigure
  typedef enum logic [2:0] {BOOT_WAIT, CFG_PWR, CFG_GYRO, IDLE, READ, ABORT} state_t;

  state_t        state, state_n;
  logic [3:0]    step, step_n;
  logic          waiting, waiting_n;
  logic [31:0]   delay_cnt, delay_n;
  logic [31:0]   div_cnt;
  logic          tick;
  logic          pending, pending_n;
  logic [BW-1:0] rd_buf, rd_buf_n;
  logic          valid_n, sample_n, error_n, overrun_n;
  logic [2:0]    op_n;
  logic [7:0]    data_n;
  logic [15:0]   gx_n, gy_n, gz_n;
`ifdef MPU_TEMP_EN
  logic [15:0]   temp_n;
`endif

  function automatic logic [10:0] seq_cmd(input state_t s, input logic [3:0] k);
    logic [10:0] c;
    c = {OP_STOP, 8'h00};
    case (s)
      CFG_PWR, CFG_GYRO: begin
        case (k)
          4'd0:    c = {OP_START, 8'h00};
          4'd1:    c = {OP_WRITE, ADDR_W};
          4'd2:    c = {OP_WRITE, (s == CFG_PWR) ? 8'h6B : 8'h1B};
          4'd3:    c = {OP_WRITE, (s == CFG_PWR) ? 8'h00 : {3'b000, GYRO_FS, 3'b000}};
          default: c = {OP_STOP, 8'h00};
        endcase
      end
      READ: begin
        if (k == 4'd0 || k == 4'd3)  c = {OP_START, 8'h00};
        else if (k == 4'd1)          c = {OP_WRITE, ADDR_W};
        else if (k == 4'd2)          c = {OP_WRITE, RD_PTR};
        else if (k == 4'd4)          c = {OP_WRITE, ADDR_R};
        else if (k < RD_NACK_STEP)   c = {OP_RACK, 8'h00};
        else if (k == RD_NACK_STEP)  c = {OP_RNACK, 8'h00};
        else                         c = {OP_STOP, 8'h00};
      end
      default: c = {OP_STOP, 8'h00};
    endcase
    return c;
  endfunction

  function automatic logic [3:0] last_step(input state_t s);
    case (s)
      CFG_PWR, CFG_GYRO: return 4'd4;
      READ:              return RD_LAST_STEP;
      default:           return 4'd0;
    endcase
  endfunction

  assign tick     = (div_cnt == DIV_LAST);
  assign busy_out = (state != IDLE) && (state != BOOT_WAIT);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 32'd1;
  end

  always_comb begin
    state_n   = state;
    step_n    = step;
    waiting_n = waiting;
    delay_n   = delay_cnt;
    pending_n = pending;
    rd_buf_n  = rd_buf;
    valid_n   = cmd_valid_out;
    op_n      = cmd_op_out;
    data_n    = cmd_data_out;
    gx_n      = gx_out;
    gy_n      = gy_out;
    gz_n      = gz_out;
`ifdef MPU_TEMP_EN
    temp_n    = temp_out;
`endif
    sample_n  = 1'b0;
    error_n   = error_out;
    overrun_n = 1'b0;

    case (state)
      BOOT_WAIT: begin
        if (delay_cnt >= DELAY_LAST) begin
          state_n = CFG_PWR;
          step_n  = 4'd0;
          delay_n = '0;
        end else begin
          delay_n = delay_cnt + 32'd1;
        end
      end
      IDLE: begin
        pending_n = 1'b0;
        if (en_in && (pending || tick)) begin
          state_n = READ;
          step_n  = 4'd0;
        end
      end
      default: begin
        // Ticks only count once configured; disabling drops any queued read.
        if (state == READ) begin
          if (!en_in)       pending_n = 1'b0;
          else if (tick) begin
            if (pending)    overrun_n = 1'b1;
            else            pending_n = 1'b1;
          end
        end

        if (cmd_valid_out) begin
          if (cmd_ready_in) begin
            valid_n   = 1'b0;
            waiting_n = 1'b1;
          end
        end else if (!waiting) begin
          valid_n         = 1'b1;
          {op_n, data_n}  = seq_cmd(state, step);
        end else if (rsp_valid_in) begin
          waiting_n = 1'b0;
          if (cmd_op_out == OP_WRITE && rsp_nack_in) begin
            error_n   = 1'b1;
            pending_n = 1'b0;
            state_n   = ABORT;
            step_n    = 4'd0;
          end else begin
            if (cmd_op_out == OP_RACK || cmd_op_out == OP_RNACK)
              rd_buf_n = {rd_buf[BW-9:0], rsp_data_in};
            if (step == last_step(state)) begin
              step_n = 4'd0;
              case (state)
                CFG_PWR:  state_n = CFG_GYRO;
                CFG_GYRO: state_n = IDLE;
                READ: begin
                  state_n  = IDLE;
                  sample_n = 1'b1;
                  gx_n     = rd_buf[47:32];
                  gy_n     = rd_buf[31:16];
                  gz_n     = rd_buf[15:0];
`ifdef MPU_TEMP_EN
                  temp_n   = rd_buf[63:48];
`endif
                end
                default: begin
                  state_n = BOOT_WAIT;
                  delay_n = '0;
                end
              endcase
            end else begin
              step_n         = step + 4'd1;
              valid_n        = 1'b1;
              {op_n, data_n} = seq_cmd(state, step + 4'd1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= BOOT_WAIT;
      step             <= '0;
      waiting          <= 1'b0;
      delay_cnt        <= '0;
      pending          <= 1'b0;
      rd_buf           <= '0;
      cmd_valid_out    <= 1'b0;
      cmd_op_out       <= '0;
      cmd_data_out     <= '0;
      gx_out           <= '0;
      gy_out           <= '0;
      gz_out           <= '0;
`ifdef MPU_TEMP_EN
      temp_out         <= '0;
`endif
      sample_valid_out <= 1'b0;
      error_out        <= 1'b0;
      overrun_out      <= 1'b0;
    end else begin
      state            <= state_n;
      step             <= step_n;
      waiting          <= waiting_n;
      delay_cnt        <= delay_n;
      pending          <= pending_n;
      rd_buf           <= rd_buf_n;
      cmd_valid_out    <= valid_n;
      cmd_op_out       <= op_n;
      cmd_data_out     <= data_n;
      gx_out           <= gx_n;
      gy_out           <= gy_n;
      gz_out           <= gz_n;
`ifdef MPU_TEMP_EN
      temp_out         <= temp_n;
`endif
      sample_valid_out <= sample_n;
      error_out        <= error_n;
      overrun_out      <= overrun_n;
    end
  end

endmodule

// File: tb/tb_mpu_i2c_sequencer.sv
// Bench for mpu_i2c_sequencer: behavioural I2C master model with random read data, op-sequence
// scoreboard and sample reference values derived from the bytes the model returned.
module tb_mpu_i2c_sequencer;

  localparam int INIT_DELAY = 10;
  localparam int SAMPLE_DIV = 200;

  logic        clk_in = 1'b0;
  logic        rst_in, en_in, cmd_ready_in, rsp_valid_in, rsp_nack_in;
  logic [7:0]  rsp_data_in;
  logic        cmd_valid_out;
  logic [2:0]  cmd_op_out;
  logic [7:0]  cmd_data_out;
  logic [15:0] gx_out, gy_out, gz_out;
  logic        sample_valid_out, busy_out, error_out, overrun_out;

  mpu_i2c_sequencer #(
    .DEV_ADDR(7'h68), .SAMPLE_DIV(SAMPLE_DIV), .INIT_DELAY(INIT_DELAY), .GYRO_FS(2'b00)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in),
    .cmd_valid_out(cmd_valid_out), .cmd_ready_in(cmd_ready_in),
    .cmd_op_out(cmd_op_out), .cmd_data_out(cmd_data_out),
    .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_nack_in(rsp_nack_in),
    .gx_out(gx_out), .gy_out(gy_out), .gz_out(gz_out),
    .sample_valid_out(sample_valid_out), .busy_out(busy_out),
    .error_out(error_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // reference op streams: {op, data}
  function automatic logic [10:0] exp_cfg(input int i);
    case (i)
      0, 5:    return {3'd0, 8'h00};
      1, 6:    return {3'd1, 8'hD0};
      2:       return {3'd1, 8'h6B};
      3:       return {3'd1, 8'h00};
      7:       return {3'd1, 8'h1B};
      8:       return {3'd1, 8'h00};
      default: return {3'd4, 8'h00};
    endcase
  endfunction

  function automatic logic [10:0] exp_read(input int i);
    case (i)
      0, 3:          return {3'd0, 8'h00};
      1:             return {3'd1, 8'hD0};
      2:             return {3'd1, 8'h43};
      4:             return {3'd1, 8'hD1};
      5, 6, 7, 8, 9: return {3'd2, 8'h00};
      10:            return {3'd3, 8'h00};
      default:       return {3'd4, 8'h00};
    endcase
  endfunction

  // master model state
  int          latency    = 3;
  int          stall_left = 0;
  bit          stalling   = 0;
  logic [10:0] st_cmd;
  bit          nack_arm   = 0;
  logic [7:0]  nack_data  = 8'h00;
  int          m_cnt      = 0;
  logic [2:0]  m_op;
  logic [7:0]  m_data;
  logic [10:0] log_q[$];
  logic [7:0]  rb[$];
  logic [7:0]  fixed_q[$];
  logic [7:0]  b;
  logic [15:0] exp_gx = 16'h0, exp_gy = 16'h0, exp_gz = 16'h0;
  int          n_samples = 0;
  int          n_overrun = 0;
  int          rise_gap  = -1;

  initial begin
    cmd_ready_in = 1'b1;
    rsp_valid_in = 1'b0;
    rsp_nack_in  = 1'b0;
    rsp_data_in  = 8'h00;
    forever begin
      @(negedge clk_in);
      rsp_valid_in = 1'b0;
      rsp_nack_in  = 1'b0;
      rsp_data_in  = 8'h00;
      if (rst_in) begin
        m_cnt        = 0;
        stalling     = 0;
        stall_left   = 0;
        cmd_ready_in = 1'b1;
      end else begin
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            rsp_valid_in = 1'b1;
            rsp_data_in  = 8'($urandom);
            if (m_op == 3'd1) begin
              rsp_nack_in = nack_arm && (m_data == nack_data);
              if (rsp_nack_in) nack_arm = 0;
            end else begin
              rsp_nack_in = 1'($urandom_range(0, 1));
            end
            if (m_op == 3'd2 || m_op == 3'd3) begin
              b = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
              rsp_data_in = b;
              rb.push_back(b);
              if (m_op == 3'd3 && rb.size() == 6) begin
                exp_gx = {rb[0], rb[1]};
                exp_gy = {rb[2], rb[3]};
                exp_gz = {rb[4], rb[5]};
              end
            end
          end
        end
        if (stall_left > 0 && (cmd_valid_out || stalling)) begin
          if (stalling) begin
            check("stall_valid", 32'(cmd_valid_out), 32'd1);
            check("stall_cmd", 32'({cmd_op_out, cmd_data_out}), 32'(st_cmd));
          end else begin
            stalling = 1;
            st_cmd   = {cmd_op_out, cmd_data_out};
          end
          stall_left--;
          cmd_ready_in = 1'b0;
        end else begin
          cmd_ready_in = 1'b1;
        end
        if (cmd_valid_out && cmd_ready_in) begin
          log_q.push_back({cmd_op_out, cmd_data_out});
          m_op     = cmd_op_out;
          m_data   = cmd_data_out;
          m_cnt    = latency;
          stalling = 0;
          if (cmd_op_out == 3'd0) rb.delete();
        end
      end
    end
  end

  // output monitor
  initial begin
    int   cyc = 0;
    int   last_sample = 0;
    logic prev_valid = 1'b0;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (rst_in) begin
        prev_valid = 1'b0;
      end else begin
        if (sample_valid_out) begin
          n_samples++;
          last_sample = cyc;
          check("sample_gx", 32'(gx_out), 32'(exp_gx));
          check("sample_gy", 32'(gy_out), 32'(exp_gy));
          check("sample_gz", 32'(gz_out), 32'(exp_gz));
          check("busy_at_sample", 32'(busy_out), 32'd0);
        end
        if (overrun_out) n_overrun++;
        if (cmd_valid_out && !prev_valid) rise_gap = cyc - last_sample;
        prev_valid = cmd_valid_out;
      end
    end
  end

  task automatic wait_samples(input string tag, input int target, input int budget);
    int t = 0;
    while (n_samples < target && t < budget) begin
      @(negedge clk_in);
      t++;
    end
    if (n_samples < target) check({tag, "_timeout"}, 32'(n_samples), 32'(target));
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int t = 0;
    while (log_q.size() < n && t < budget) begin
      @(negedge clk_in);
      t++;
    end
    if (log_q.size() < n) check({tag, "_timeout"}, 32'(log_q.size()), 32'(n));
  endtask

  task automatic check_read(input string tag);
    if (log_q.size() < 12) begin
      check({tag, "_len"}, 32'(log_q.size()), 32'd12);
    end else begin
      for (int i = 0; i < 12; i++)
        check($sformatf("%s_op%0d", tag, i), 32'(log_q[i]), 32'(exp_read(i)));
    end
    log_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},  32'(cmd_valid_out), 32'd0);
    check({tag, "_op"},     32'({cmd_op_out, cmd_data_out}), 32'd0);
    check({tag, "_busy"},   32'(busy_out), 32'd0);
    check({tag, "_error"},  32'(error_out), 32'd0);
    check({tag, "_strobe"}, 32'({sample_valid_out, overrun_out}), 32'd0);
    check({tag, "_gyro"},   32'(gx_out | gy_out | gz_out), 32'd0);
  endtask

  task automatic boot_and_config(input string tag);
    int cyc = 0;
    @(negedge clk_in);
    rst_in = 1'b0;
    do begin
      @(negedge clk_in);
      cyc++;
    end while (!cmd_valid_out && cyc < 100);
    check({tag, "_first_cmd_cycle"}, 32'(cyc), 32'd11);
    wait_log({tag, "_cfg"}, 10, 400);
    for (int i = 0; i < 10 && i < log_q.size(); i++)
      check($sformatf("%s_cfg%0d", tag, i), 32'(log_q[i]), 32'(exp_cfg(i)));
    log_q.delete();
  endtask

  int          ns;
  int          t;
  logic [15:0] hold_gx, hold_gy, hold_gz;

  initial begin
    en_in  = 1'b1;
    rst_in = 1'b1;
    fixed_q = '{8'h12, 8'h34, 8'hFF, 8'hFE, 8'h00, 8'h05};
    repeat (3) @(negedge clk_in);
    check_zero_outputs("reset");
    boot_and_config("boot");

    // first read with the fixed byte pattern
    wait_samples("rd1", 1, 600);
    check_read("rd1");
    check("gx_fixed", 32'(gx_out), 32'h1234);
    check("gy_fixed", 32'(gy_out), 32'hFFFE);
    check("gz_fixed", 32'(gz_out), 32'h0005);

    for (int r = 0; r < 3; r++) begin
      wait_samples("rd_rand", n_samples + 1, 600);
      check_read($sformatf("rd_rand%0d", r));
    end

    // ready held low for 7 cycles on the next command
    stall_left = 7;
    wait_samples("rd_stall", n_samples + 1, 600);
    check_read("rd_stall");
    check("stall_consumed", 32'(stall_left), 32'd0);

    // slow master: pending on the second tick, overrun on the third
    latency = 40;
    wait_samples("rd_slow", n_samples + 1, 1500);
    latency = 3;
    check_read("rd_slow");
    check("overrun_once", 32'(n_overrun), 32'd1);
    repeat (5) @(negedge clk_in);
    check("pending_restart_gap", 32'(rise_gap), 32'd2);
    wait_samples("rd_pend", n_samples + 1, 300);
    check_read("rd_pend");

    // en_in dropped mid-read: sample still delivered, nothing queued
    latency = 40;
    t = 0;
    while (!busy_out && t < 400) begin
      @(negedge clk_in);
      t++;
    end
    check("en_read_started", 32'(busy_out), 32'd1);
    repeat (250) @(negedge clk_in);
    en_in = 1'b0;
    wait_samples("rd_en_low", n_samples + 1, 800);
    latency = 3;
    check_read("rd_en_low");
    ns = n_samples;
    repeat (450) @(negedge clk_in);
    check("en_low_no_cmds", 32'(log_q.size()), 32'd0);
    check("en_low_no_samples", 32'(n_samples), 32'(ns));
    check("en_low_no_overrun", 32'(n_overrun), 32'd1);
    en_in = 1'b1;
    wait_samples("rd_en_back", n_samples + 1, 600);
    check_read("rd_en_back");

    // NACK on the register pointer write
    hold_gx = exp_gx;
    hold_gy = exp_gy;
    hold_gz = exp_gz;
    ns = n_samples;
    nack_data = 8'h43;
    nack_arm  = 1;
    wait_log("nack", 14, 800);
    for (int i = 0; i < 14 && i < log_q.size(); i++)
      check($sformatf("nack_seq%0d", i), 32'(log_q[i]),
            32'((i < 3) ? exp_read(i) : (i == 3) ? {3'd4, 8'h00} : exp_cfg(i - 4)));
    log_q.delete();
    check("nack_error", 32'(error_out), 32'd1);
    check("nack_no_sample", 32'(n_samples), 32'(ns));
    check("nack_hold_gyro", 32'({gx_out, gy_out}), 32'({hold_gx, hold_gy}));
    check("nack_hold_gz", 32'(gz_out), 32'(hold_gz));
    wait_samples("rd_after_nack", n_samples + 1, 600);
    check_read("rd_after_nack");
    check("error_sticky", 32'(error_out), 32'd1);

    // asynchronous reset in the middle of a read
    t = 0;
    while (!(cmd_valid_out && cmd_op_out == 3'd2) && t < 600) begin
      @(negedge clk_in);
      t++;
    end
    check("midread_reached", 32'(cmd_op_out), 32'd2);
    #3 rst_in = 1'b1;
    #1 check_zero_outputs("async_rst");
    repeat (2) @(negedge clk_in);
    log_q.delete();
    exp_gx = 16'h0;
    exp_gy = 16'h0;
    exp_gz = 16'h0;
    boot_and_config("reboot");
    wait_samples("rd_reboot", n_samples + 1, 600);
    check_read("rd_reboot");
    check("final_overrun_count", 32'(n_overrun), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
